// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles every signal between the 5-stage pipeline datapath and the hazard
// sequencer.
//   Hazard inputs (datapath -> sequencer):
//     ihit, dhit, dREN_MEM, dWEN_MEM, memtoReg_EX, rt_EX[4:0], rs_ID[4:0],
//     rt_ID[4:0], uses_rt_ID, redirect_EX, halt_WB
//   Control outputs (sequencer -> datapath):
//     pc_en, ifid/idex/exmem/memwb _en and _flush, halted,
//     stall_cnt[CNT_W-1:0], flush_cnt[CNT_W-1:0]
//   Modports: master = datapath side, slave = hazard sequencer.
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             dREN_MEM;
    logic             dWEN_MEM;
    logic             memtoReg_EX;
    logic [4:0]       rt_EX;
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic             uses_rt_ID;
    logic             redirect_EX;
    logic             halt_WB;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, dREN_MEM, dWEN_MEM, memtoReg_EX, rt_EX, rs_ID,
               rt_ID, uses_rt_ID, redirect_EX, halt_WB,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_flush, exmem_flush, memwb_flush, halted, stall_cnt,
               flush_cnt
    );

    modport slave (
        input  ihit, dhit, dREN_MEM, dWEN_MEM, memtoReg_EX, rt_EX, rs_ID,
               rt_ID, uses_rt_ID, redirect_EX, halt_WB,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_flush, exmem_flush, memwb_flush, halted, stall_cnt,
               flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Produces the
// PC and pipeline-register enables/flushes for load-use hazards, I/D memory
// wait cycles, EX-stage redirects and the terminal halt, and keeps saturating
// stall/flush event counters.
//   CLK  : clock
//   nRST : asynchronous active-low reset
//   bus  : pipeline_hazard_ctrl_if.slave (hazard inputs, control outputs,
//          halted flag, stall_cnt / flush_cnt)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                        CLK,
    input  logic                        nRST,
    pipeline_hazard_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    state_t           state;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic mem_pend;
    logic lu;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

    // Enables and flushes are combinational so a stall/flush decision lands
    // on the very next edge. The priority order matters: an outstanding data
    // access freezes everything upstream of WB (and bubbles WB so the MEM
    // instruction is not written twice); a redirect then beats the
    // load-use and I-miss stalls because the fetched path is discarded anyway.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        mem_pend = (bus.dREN_MEM | bus.dWEN_MEM) & ~bus.dhit;
        lu       = bus.memtoReg_EX & (bus.rt_EX != 5'd0) &
                   ((bus.rt_EX == bus.rs_ID) |
                    (bus.uses_rt_ID & (bus.rt_EX == bus.rt_ID)));

        if (nRST && (state != HALTED)) begin
            if (mem_pend) begin
                memwb_en    = 1'b1;
                memwb_flush = 1'b1;
            end else if (bus.redirect_EX) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (lu || !bus.ihit) begin
                // Hold PC and IF/ID, push one bubble into ID/EX.
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    // State machine, sticky halted flag and saturating event counters.
    // halt_WB wins over every other transition; counters still count the
    // cycle in which halt_WB is first seen and freeze from then on.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state != HALTED) begin
                if (!pc_en && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
                if (ifid_flush && (flush_cnt != '1)) begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
            end

            if (bus.halt_WB) begin
                state  <= HALTED;
                halted <= 1'b1;
            end else begin
                case (state)
                    RUN:      if (mem_pend) state <= MEM_WAIT;
                    MEM_WAIT: if (bus.dhit) state <= RUN;
                    default:  state <= HALTED;
                endcase
            end
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_flush = memwb_flush;
    assign bus.halted      = halted;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Scoreboard bench for pipeline_hazard_ctrl (CNT_W = 4 so saturation is
// reachable). A driver applies directed and random hazard patterns on the
// falling edge and queues the expected control word, halted flag and counter
// values; a monitor pops and compares shortly after.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W  = 4;
    localparam int CNTMAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic       dren;
        logic       dwen;
        logic       memtoReg;
        logic [4:0] rtEx;
        logic [4:0] rsId;
        logic [4:0] rtId;
        logic       usesRt;
        logic       redirect;
        logic       halt;
    } stim_t;

    typedef struct {
        logic [8:0] outs;
        logic       halted;
        int         stall;
        int         flush;
    } exp_t;

    logic CLK;
    logic nRST;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    exp_t queue_exp[$];
    int   tests   = 0;
    int   fails   = 0;
    bit   driving = 1'b1;

    // Reference state: whether the processor has stopped, and event totals.
    bit   mHalted;
    int   mStall;
    int   mFlush;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Control word order: pc, ifid, idex, exmem, memwb enables, then
    // ifid, idex, exmem, memwb flushes.
    function automatic logic [8:0] word(input bit pc, input bit fe, input bit de,
                                        input bit ee, input bit we, input bit ff,
                                        input bit df, input bit ef, input bit wf);
        return {pc, fe, de, ee, we, ff, df, ef, wf};
    endfunction

    function automatic logic [8:0] expectOuts(input stim_t s, input bit rstn, input bit hlt);
        bit dataWait, loadUse;
        if (!rstn || hlt) return 9'd0;
        dataWait = (s.dren || s.dwen) && !s.dhit;
        loadUse  = s.memtoReg && (s.rtEx != 5'd0) &&
                   ((s.rtEx == s.rsId) || (s.usesRt && (s.rtEx == s.rtId)));
        if (dataWait)        return word(0, 0, 0, 0, 1, 0, 0, 0, 1);
        if (s.redirect)      return word(1, 1, 1, 1, 1, 1, 1, 0, 0);
        if (loadUse || !s.ihit) return word(0, 0, 1, 1, 1, 0, 1, 0, 0);
        return word(1, 1, 1, 1, 1, 0, 0, 0, 0);
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s       = '0;
        s.ihit  = 1'b1;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.ihit     = ($urandom_range(0, 3) != 0);
        s.dhit     = 1'($urandom_range(0, 1));
        s.dren     = ($urandom_range(0, 3) == 0);
        s.dwen     = ($urandom_range(0, 5) == 0);
        s.memtoReg = 1'($urandom_range(0, 1));
        s.rtEx     = 5'($urandom_range(0, 3));
        s.rsId     = 5'($urandom_range(0, 3));
        s.rtId     = 5'($urandom_range(0, 3));
        s.usesRt   = 1'($urandom_range(0, 1));
        s.redirect = ($urandom_range(0, 4) == 0);
        s.halt     = ($urandom_range(0, 149) == 0);
        return s;
    endfunction

    task automatic driveBus(input stim_t s);
        bus.ihit        = s.ihit;
        bus.dhit        = s.dhit;
        bus.dREN_MEM    = s.dren;
        bus.dWEN_MEM    = s.dwen;
        bus.memtoReg_EX = s.memtoReg;
        bus.rt_EX       = s.rtEx;
        bus.rs_ID       = s.rsId;
        bus.rt_ID       = s.rtId;
        bus.uses_rt_ID  = s.usesRt;
        bus.redirect_EX = s.redirect;
        bus.halt_WB     = s.halt;
    endtask

    // One cycle of normal operation: drive, queue expectation, advance model.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge CLK);
        nRST = 1'b1;
        driveBus(s);
        #1;
        e.outs   = expectOuts(s, 1'b1, mHalted);
        e.halted = mHalted;
        e.stall  = mStall;
        e.flush  = mFlush;
        queue_exp.push_back(e);
        if (!mHalted) begin
            if (!e.outs[8] && mStall < CNTMAX) mStall++;
            if (e.outs[3] && mFlush < CNTMAX) mFlush++;
        end
        if (s.halt) mHalted = 1'b1;
    endtask

    // One cycle held in reset; everything must read zero.
    task automatic applyReset();
        exp_t e;
        @(negedge CLK);
        nRST = 1'b0;
        driveBus(randStim());
        #1;
        mHalted  = 1'b0;
        mStall   = 0;
        mFlush   = 0;
        e.outs   = 9'd0;
        e.halted = 1'b0;
        e.stall  = 0;
        e.flush  = 0;
        queue_exp.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle, after the inputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (!driving) break;
            if (queue_exp.size() == 0) begin
                checkOutput("scoreboard_underflow", 1, 0);
            end else begin
                e = queue_exp.pop_front();
                checkOutput("ctrl_word", int'({bus.pc_en, bus.ifid_en, bus.idex_en,
                            bus.exmem_en, bus.memwb_en, bus.ifid_flush, bus.idex_flush,
                            bus.exmem_flush, bus.memwb_flush}), int'(e.outs));
                checkOutput("halted", int'(bus.halted), int'(e.halted));
                checkOutput("stall_cnt", int'(bus.stall_cnt), e.stall);
                checkOutput("flush_cnt", int'(bus.flush_cnt), e.flush);
            end
        end
    end

    initial begin
        stim_t s;
        nRST = 1'b0;
        driveBus(idleStim());
        mHalted = 1'b0;
        mStall  = 0;
        mFlush  = 0;

        applyReset();

        // Load-use on rs, then free-running.
        s = idleStim(); s.memtoReg = 1'b1; s.rtEx = 5'd2; s.rsId = 5'd2;
        applyStimulus(s);
        applyStimulus(idleStim());
        // Load-use through rt only when rt is a source.
        s = idleStim(); s.memtoReg = 1'b1; s.rtEx = 5'd7; s.rtId = 5'd7; s.usesRt = 1'b1;
        applyStimulus(s);
        s.usesRt = 1'b0;
        applyStimulus(s);

        // D-miss for three cycles then hit.
        applyReset();
        s = idleStim(); s.dren = 1'b1;
        repeat (3) applyStimulus(s);
        s.dhit = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());

        // Redirect held behind a store miss, then applied on dhit.
        s = idleStim(); s.dwen = 1'b1; s.redirect = 1'b1;
        repeat (2) applyStimulus(s);
        s.dhit = 1'b1;
        applyStimulus(s);

        // Redirect beats load-use and I-miss together.
        applyReset();
        s = idleStim(); s.redirect = 1'b1; s.memtoReg = 1'b1; s.rtEx = 5'd3;
        s.rsId = 5'd3; s.ihit = 1'b0;
        applyStimulus(s);

        // rt_EX = 0 never stalls.
        s = idleStim(); s.memtoReg = 1'b1; s.rtEx = 5'd0; s.rsId = 5'd0;
        applyStimulus(s);

        // Halt: one cycle of halt_WB, then activity is ignored.
        s = idleStim(); s.ihit = 1'b0; s.halt = 1'b1;
        applyStimulus(s);
        repeat (5) applyStimulus(randStim());

        // Saturation of stall_cnt under a long I-miss.
        applyReset();
        s = idleStim(); s.ihit = 1'b0;
        repeat (20) applyStimulus(s);

        // Saturation of flush_cnt under repeated redirects.
        applyReset();
        s = idleStim(); s.redirect = 1'b1;
        repeat (20) applyStimulus(s);

        // Random traffic with periodic resets.
        for (int i = 0; i < 600; i++) begin
            if ((i % 150) == 149) applyReset();
            else applyStimulus(randStim());
        end

        @(negedge CLK);
        driving = 1'b0;
        #3;
        checkOutput("scoreboard_leftover", queue_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
